// File: rtl/cpu0_io_console_if.sv
// cpu0 memory-bus signals seen by the console device.
// The CPU is the master; the console snoops writes and answers status reads.
interface cpu0_io_console_if;
    // No valid/ready pair: a transfer is any cycle with en high, and the device never stalls the CPU.
    // Reads are combinational while en & rw; dbus_oe is high exactly when the device drives dbus_out.
    logic        en;
    logic        rw;
    logic [1:0]  m_size;
    logic [31:0] abus;
    logic [31:0] dbus_in;
    logic [31:0] dbus_out;
    logic        dbus_oe;

    modport master (output en, rw, m_size, abus, dbus_in, input dbus_out, dbus_oe);
    modport slave  (input en, rw, m_size, abus, dbus_in, output dbus_out, dbus_oe);
endinterface

// File: rtl/cpu0_io_console.sv
// Memory-mapped console: unpacks CPU writes into a byte FIFO and sends each byte as 8N1 UART.
// A status word at IOADDR+4 lets software poll occupancy, busy and the sticky overflow flag.
module cpu0_io_console #(
    parameter logic [31:0] IOADDR       = 32'h0001_0000,
    parameter int          DEPTH        = 16,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic              clock,
    input  logic              reset,
    cpu0_io_console_if.slave  bus,
    output logic              tx,
    output logic              tx_busy,
    output logic              overflow,
    output logic [1:0]        fsm_state
);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          CW       = $clog2(CLKS_PER_BIT);
    localparam logic [31:0] STATADDR = IOADDR + 32'd4;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state, state_d;
    logic          wr_q, wr_q_d, accept, stat_wr, stat_rd;
    logic [3:0]    new_mask, stg_mask, stg_clr;
    logic [31:0]   stg_data;
    logic [7:0]    stg_byte;
    logic          push, push_ok, pop, full, empty, ovf_set;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    count;
    logic [7:0]    shreg, shreg_d;
    logic [2:0]    bitcnt, bitcnt_d;
    logic [CW-1:0] clkcnt, clkcnt_d;
    logic          bit_end, tx_d;

    // Bus decode: only the first cycle of a data-address write is taken.
    assign wr_q    = bus.en & ~bus.rw & (bus.abus == IOADDR);
    assign accept  = wr_q & ~wr_q_d;
    assign stat_wr = bus.en & ~bus.rw & (bus.abus == STATADDR) & bus.dbus_in[0];
    assign stat_rd = bus.en & bus.rw & (bus.abus == STATADDR);

    // A zero low byte means "nothing to print"; upper bytes are printed only when nonzero.
    always_comb begin
        new_mask = 4'b0000;
        if (bus.dbus_in[7:0] != 8'h00) begin
            new_mask[0] = 1'b1;
            for (int i = 1; i < 4; i++) begin
                new_mask[i] = (2'(i) <= bus.m_size) && (bus.dbus_in[8*i +: 8] != 8'h00);
            end
        end
    end

    always_comb begin
        stg_byte = 8'h00;
        stg_clr  = 4'b0000;
        if (stg_mask[0]) begin
            stg_byte = stg_data[7:0];
            stg_clr  = 4'b0001;
        end else if (stg_mask[1]) begin
            stg_byte = stg_data[15:8];
            stg_clr  = 4'b0010;
        end else if (stg_mask[2]) begin
            stg_byte = stg_data[23:16];
            stg_clr  = 4'b0100;
        end else if (stg_mask[3]) begin
            stg_byte = stg_data[31:24];
            stg_clr  = 4'b1000;
        end
    end

    assign push    = |stg_mask;
    assign empty   = (count == 8'd0);
    assign full    = (count == 8'(DEPTH));
    assign pop     = (state == S_IDLE) && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop);
    assign ovf_set = (push && !push_ok) || (accept && push);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_q_d   <= 1'b0;
            stg_mask <= 4'b0000;
            stg_data <= 32'h0;
        end else begin
            wr_q_d <= wr_q;
            if (accept && !push) begin
                stg_mask <= new_mask;
                stg_data <= bus.dbus_in;
            end else begin
                stg_mask <= stg_mask & ~stg_clr;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= stg_byte;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 8'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count    <= count + {7'b0, push_ok} - {7'b0, pop};
            overflow <= ovf_set | (overflow & ~stat_wr);
        end
    end

    assign bit_end = (clkcnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d  = state;
        shreg_d  = shreg;
        bitcnt_d = bitcnt;
        clkcnt_d = clkcnt;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_d  = S_START;
                    shreg_d  = mem[rd_ptr];
                    bitcnt_d = 3'd0;
                    clkcnt_d = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d  = S_DATA;
                    clkcnt_d = '0;
                end else begin
                    clkcnt_d = clkcnt + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    clkcnt_d = '0;
                    if (bitcnt == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bitcnt_d = bitcnt + 3'd1;
                        shreg_d  = {1'b0, shreg[7:1]};
                    end
                end else begin
                    clkcnt_d = clkcnt + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d  = S_IDLE;
                    clkcnt_d = '0;
                end else begin
                    clkcnt_d = clkcnt + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Line level follows the next state so tx is a clean register output.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= S_IDLE;
            shreg  <= 8'h00;
            bitcnt <= 3'd0;
            clkcnt <= '0;
            tx     <= 1'b1;
        end else begin
            state  <= state_d;
            shreg  <= shreg_d;
            bitcnt <= bitcnt_d;
            clkcnt <= clkcnt_d;
            tx     <= tx_d;
        end
    end

    assign tx_busy   = (state != S_IDLE);
    assign fsm_state = state;

    assign bus.dbus_oe  = stat_rd;
    assign bus.dbus_out = stat_rd ? {20'b0, overflow, tx_busy, empty, full, count}
                                  : 32'hzzzz_zzzz;
endmodule

// File: tb/tb_cpu0_io_console.sv
// Bench for cpu0_io_console: two instances (4 and 16 clocks per bit) driven over the bus,
// UART frames decoded per instance and checked against an expected-byte queue.
module tb_cpu0_io_console;
    localparam logic [31:0] IOADDR = 32'h0001_0000;
    localparam int          CPB_A  = 4;
    localparam int          CPB_B  = 16;

    logic       clock = 1'b0;
    logic       reset_a, reset_b;
    logic       tx_a, tx_busy_a, overflow_a;
    logic       tx_b, tx_busy_b, overflow_b;
    logic [1:0] state_a, state_b;
    logic       mon_en_a = 1'b1;
    logic       mon_en_b = 1'b1;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];

    typedef struct packed {
        logic [1:0]  size;
        logic [31:0] data;
        logic [2:0]  n;
        logic [31:0] bytes;
    } vec_t;

    cpu0_io_console_if bus_a();
    cpu0_io_console_if bus_b();

    cpu0_io_console #(.IOADDR(IOADDR), .DEPTH(16), .CLKS_PER_BIT(CPB_A)) dut_a (
        .clock(clock), .reset(reset_a), .bus(bus_a.slave),
        .tx(tx_a), .tx_busy(tx_busy_a), .overflow(overflow_a), .fsm_state(state_a)
    );

    cpu0_io_console #(.IOADDR(IOADDR), .DEPTH(16), .CLKS_PER_BIT(CPB_B)) dut_b (
        .clock(clock), .reset(reset_b), .bus(bus_b.slave),
        .tx(tx_b), .tx_busy(tx_busy_b), .overflow(overflow_b), .fsm_state(state_b)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic sb_push(input int sel, input logic [7:0] b);
        if (sel == 0) exp_q_a.push_back(b);
        else          exp_q_b.push_back(b);
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? exp_q_a.size() : exp_q_b.size();
    endfunction

    function automatic logic tx_of(input int sel);
        return (sel == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? tx_busy_a : tx_busy_b;
    endfunction

    // Bus drivers
    task automatic bus_drive(input int sel, input logic en, input logic rw, input logic [1:0] sz,
                             input logic [31:0] addr, input logic [31:0] data);
        if (sel == 0) begin
            bus_a.en = en; bus_a.rw = rw; bus_a.m_size = sz; bus_a.abus = addr; bus_a.dbus_in = data;
        end else begin
            bus_b.en = en; bus_b.rw = rw; bus_b.m_size = sz; bus_b.abus = addr; bus_b.dbus_in = data;
        end
    endtask

    task automatic cpu_write(input int sel, input logic [31:0] addr, input logic [1:0] sz,
                             input logic [31:0] data, input int hold);
        @(negedge clock);
        bus_drive(sel, 1'b1, 1'b0, sz, addr, data);
        repeat (hold) @(negedge clock);
        bus_drive(sel, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic cpu_read(input int sel, input logic [31:0] addr,
                            output logic oe, output logic [31:0] data);
        @(negedge clock);
        bus_drive(sel, 1'b1, 1'b1, 2'b11, addr, 32'h0);
        #1;
        oe   = (sel == 0) ? bus_a.dbus_oe  : bus_b.dbus_oe;
        data = (sel == 0) ? bus_a.dbus_out : bus_b.dbus_out;
        @(negedge clock);
        bus_drive(sel, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic wait_busy(input int sel, input logic lvl, input int budget,
                             input string name, output int cycles);
        cycles = 0;
        while (busy_of(sel) !== lvl && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
        if (busy_of(sel) !== lvl) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: tx_busy=%0b after %0d clocks, expected %0b", name, busy_of(sel), cycles, lvl);
        end
    endtask

    task automatic wait_drain(input int sel, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clock);
            done = (qsize(sel) == 0) && !busy_of(sel);
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: %0d bytes still outstanding at timeout, expected 0", name, qsize(sel));
        end
        repeat (60) @(negedge clock);
    endtask

    // UART decoder: samples mid-bit on falling clock edges and pops the expected byte.
    task automatic uart_monitor(input int sel, input int cpb);
        logic [7:0] rx;
        logic [7:0] exp_b;
        forever begin
            @(negedge clock);
            if (((sel == 0) ? mon_en_a : mon_en_b) && tx_of(sel) == 1'b0) begin
                repeat (cpb / 2) @(negedge clock);
                check($sformatf("start_bit_%0d", sel), 32'(tx_of(sel)), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (cpb) @(negedge clock);
                    rx[i] = tx_of(sel);
                end
                repeat (cpb) @(negedge clock);
                check($sformatf("stop_bit_%0d", sel), 32'(tx_of(sel)), 32'd1);
                if (qsize(sel) == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_frame_%0d: got unexpected byte 0x%02h, expected no frame", sel, rx);
                end else begin
                    exp_b = (sel == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
                    check($sformatf("rx_frame_%0d", sel), 32'(rx), 32'(exp_b));
                end
            end
        end
    endtask

    initial uart_monitor(0, CPB_A);
    initial uart_monitor(1, CPB_B);

    // Main sequence
    initial begin
        vec_t        vecs[9];
        logic        oe;
        logic [31:0] rd;
        logic [7:0]  wave_byte;
        logic        exp_tx, exp_bz;
        int          cyc;

        vecs[0] = '{size: 2'd0, data: 32'h0000_0041, n: 3'd1, bytes: 32'h0000_0041};
        vecs[1] = '{size: 2'd0, data: 32'hFFFF_5A61, n: 3'd1, bytes: 32'h0000_0061};
        vecs[2] = '{size: 2'd3, data: 32'h0043_4241, n: 3'd3, bytes: 32'h0043_4241};
        vecs[3] = '{size: 2'd3, data: 32'h0000_4100, n: 3'd0, bytes: 32'h0000_0000};
        vecs[4] = '{size: 2'd1, data: 32'h0000_4342, n: 3'd2, bytes: 32'h0000_4342};
        vecs[5] = '{size: 2'd2, data: 32'h0044_0045, n: 3'd2, bytes: 32'h0000_4445};
        vecs[6] = '{size: 2'd3, data: 32'h4443_4241, n: 3'd4, bytes: 32'h4443_4241};
        vecs[7] = '{size: 2'd2, data: 32'h7A7A_0000, n: 3'd0, bytes: 32'h0000_0000};
        vecs[8] = '{size: 2'd1, data: 32'h0031_0030, n: 3'd1, bytes: 32'h0000_0030};

        bus_drive(0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        bus_drive(1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_tx_a", 32'(tx_a), 32'd1);
        check("reset_busy_a", 32'(tx_busy_a), 32'd0);
        check("reset_ovf_a", 32'(overflow_a), 32'd0);
        check("reset_tx_b", 32'(tx_b), 32'd1);
        reset_a = 1'b1;
        reset_b = 1'b1;
        cpu_read(0, IOADDR + 32'd4, oe, rd);
        check("reset_status_oe", 32'(oe), 32'd1);
        check("reset_status", rd, 32'h0000_0200);

        // Exact waveform of one byte frame, sampled every clock from the clock after the write.
        cpu_write(0, IOADDR, 2'd0, 32'h0000_0041, 1);
        sb_push(0, 8'h41);
        wave_byte = 8'h41;
        for (int k = 0; k < 42; k++) begin
            @(negedge clock);
            exp_bz = (k >= 1 && k <= 40);
            if (k >= 1 && k <= 4)       exp_tx = 1'b0;
            else if (k >= 5 && k <= 36) exp_tx = wave_byte[(k - 5) / 4];
            else                        exp_tx = 1'b1;
            check($sformatf("wave_tx_%0d", k), 32'(tx_a), 32'(exp_tx));
            check($sformatf("wave_busy_%0d", k), 32'(tx_busy_a), 32'(exp_bz));
        end
        wait_drain(0, "wave_drain");

        // Unpacker vectors
        for (int v = 0; v < 9; v++) begin
            cpu_write(0, IOADDR, vecs[v].size, vecs[v].data, 1);
            for (int j = 0; j < int'(vecs[v].n); j++) sb_push(0, vecs[v].bytes[8*j +: 8]);
            wait_drain(0, $sformatf("vec%0d_drain", v));
            check($sformatf("vec%0d_ovf", v), 32'(overflow_a), 32'd0);
        end

        // One idle clock between back-to-back frames
        cpu_write(0, IOADDR, 2'd3, 32'h0043_4241, 1);
        sb_push(0, 8'h41); sb_push(0, 8'h42); sb_push(0, 8'h43);
        wait_busy(0, 1'b1, 20, "gap_first_busy", cyc);
        for (int g = 0; g < 2; g++) begin
            wait_busy(0, 1'b0, 100, "gap_fall", cyc);
            wait_busy(0, 1'b1, 20, "gap_rise", cyc);
            check($sformatf("gap_clocks_%0d", g), 32'(cyc), 32'd1);
        end
        wait_drain(0, "gap_drain");

        // Status word while bytes are pending behind a frame in flight
        cpu_write(0, IOADDR, 2'd0, 32'h0000_0058, 1);
        cpu_write(0, IOADDR, 2'd3, 32'h0043_4241, 1);
        sb_push(0, 8'h58); sb_push(0, 8'h41); sb_push(0, 8'h42); sb_push(0, 8'h43);
        repeat (4) @(negedge clock);
        cpu_read(0, IOADDR + 32'd4, oe, rd);
        check("pend_status_3", rd, 32'h0000_0403);
        cpu_read(0, IOADDR + 32'd8, oe, rd);
        check("pend_plus8_oe", 32'(oe), 32'd0);
        cpu_read(0, IOADDR, oe, rd);
        check("pend_data_read_oe", 32'(oe), 32'd0);
        wait_busy(0, 1'b0, 100, "pend_fall", cyc);
        wait_busy(0, 1'b1, 20, "pend_rise", cyc);
        cpu_read(0, IOADDR + 32'd4, oe, rd);
        check("pend_status_2", rd, 32'h0000_0402);
        wait_drain(0, "pend_drain");

        // Write while staging still holds bytes is dropped and flags overflow
        cpu_write(0, IOADDR, 2'd3, 32'h4443_4241, 1);
        cpu_write(0, IOADDR, 2'd0, 32'h0000_005A, 1);
        sb_push(0, 8'h41); sb_push(0, 8'h42); sb_push(0, 8'h43); sb_push(0, 8'h44);
        repeat (2) @(negedge clock);
        check("stage_drop_ovf", 32'(overflow_a), 32'd1);
        cpu_read(0, IOADDR + 32'd4, oe, rd);
        check("stage_drop_status_ovf", 32'(rd[11]), 32'd1);
        cpu_write(0, IOADDR + 32'd4, 2'd0, 32'h0000_0002, 1);
        @(negedge clock);
        check("ovf_kept_bit0_zero", 32'(overflow_a), 32'd1);
        cpu_write(0, IOADDR + 32'd4, 2'd0, 32'h0000_0001, 1);
        @(negedge clock);
        check("ovf_cleared_a", 32'(overflow_a), 32'd0);
        wait_drain(0, "stage_drain");

        // en held for three clocks gives one frame
        cpu_write(0, IOADDR, 2'd0, 32'h0000_0047, 3);
        sb_push(0, 8'h47);
        wait_drain(0, "hold_drain");
        cpu_read(0, IOADDR + 32'd4, oe, rd);
        check("hold_status_idle", rd, 32'h0000_0200);

        // FIFO fill and overflow at 16 clocks per bit
        for (int i = 0; i < 18; i++) begin
            cpu_write(1, IOADDR, 2'd0, 32'h30 + 32'(i), 1);
            if (i < 17) sb_push(1, 8'h30 + 8'(i));
            repeat (2) @(negedge clock);
        end
        check("fill_ovf_b", 32'(overflow_b), 32'd1);
        cpu_read(1, IOADDR + 32'd4, oe, rd);
        check("fill_status", rd, 32'h0000_0D10);
        cpu_write(1, IOADDR + 32'd4, 2'd0, 32'h0000_0001, 1);
        @(negedge clock);
        check("fill_ovf_cleared", 32'(overflow_b), 32'd0);
        cpu_read(1, IOADDR + 32'd4, oe, rd);
        check("fill_status_cleared", rd, 32'h0000_0510);
        wait_drain(1, "fill_drain");

        // Reset in the middle of the data bits
        mon_en_a = 1'b0;
        cpu_write(0, IOADDR, 2'd0, 32'h0000_0055, 1);
        cyc = 0;
        while (state_a != 2'd2 && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        check("midreset_reached_data", 32'(state_a), 32'd2);
        repeat (5) @(negedge clock);
        reset_a = 1'b0;
        @(negedge clock);
        check("midreset_tx", 32'(tx_a), 32'd1);
        check("midreset_busy", 32'(tx_busy_a), 32'd0);
        check("midreset_state", 32'(state_a), 32'd0);
        cpu_read(0, IOADDR + 32'd4, oe, rd);
        check("midreset_status", rd, 32'h0000_0200);
        reset_a = 1'b1;
        repeat (60) @(negedge clock);
        check("midreset_line_idle", 32'(tx_a), 32'd1);
        mon_en_a = 1'b1;
        cpu_write(0, IOADDR, 2'd0, 32'h0000_005A, 1);
        sb_push(0, 8'h5A);
        wait_drain(0, "post_reset_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
